seg7_scan_capture: RTL

Receive-side counterpart of the seven-segment encoder. Monitors a multiplexed, active-low seven-segment bus: segment lines plus one-hot active-low digit enables. Each stable pattern is decoded back to a 4-bit digit and stored per digit position. Used for loopback self-check of the display path and as a scoreboard front-end in system benches.

---
 rtl/seg7_scan_capture.sv | 114 +++++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: decodes a multiplexed active-low seven-segment bus back into per-digit values
//   clk, rst_n    : clock, asynchronous active-low reset
//   seg_n, an_n   : monitored segment lines (bit6=a..bit0=g) and digit enables, 0=active
//   digits        : decoded value per digit, digit i at [4i+3:4i]
//   digit_valid   : digit i has been committed since reset
//   blank         : last accepted pattern on digit i was blank
//   commit        : pulse, a pattern was accepted; commit_idx names the digit
//   bad_pattern   : pulse, a stable pattern was not in the code table
//   frame_done    : pulse, every digit committed since the previous frame_done
module seg7_scan_capture #(
   parameter int NUM_DIGITS = 4,
   parameter int STABLE_CYCLES = 4,
   localparam int IDX_W = $clog2(NUM_DIGITS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   blank,
   output logic                    commit,
   output logic [IDX_W-1:0]        commit_idx,
   output logic                    bad_pattern,
   output logic                    frame_done
);
   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
   typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;
   state_t state, state_nxt;
   logic [6:0] s_seg, p_seg;
   logic [NUM_DIGITS-1:0] s_an, p_an, sel, seen, seen_all;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [IDX_W-1:0] idx;
   logic [3:0] code_val;
   logic one_hot, same, held_same, accept, code_ok, code_blank;
   assign sel = ~s_an;
   assign one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   // p_* is the sample one cycle older, so "same" means the bus held still for a cycle
   assign same = (s_an == p_an) && (s_seg == p_seg);
   assign held_same = (state == HELD) && same;
   assign cnt_nxt = !one_hot ? '0 :
                    held_same ? cnt :
                    (state == TRACK && same) ? ((cnt == STABLE) ? cnt : cnt + 1'b1) :
                    CNT_W'(1);
   // a fresh or changed pattern counts as 1, so STABLE_CYCLES=1 accepts on its first look
   assign accept = one_hot && !held_same && (cnt_nxt == STABLE);
   assign state_nxt = !one_hot ? IDLE : (accept || held_same) ? HELD : TRACK;
   assign seen_all = seen | sel;
   always_comb begin
      idx = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         if (sel[k]) idx = IDX_W'(k);
   end
   always_comb begin
      code_ok = 1'b1;
      code_blank = 1'b0;
      code_val = 4'd0;
      case (s_seg)
         7'b0000001: code_val = 4'd0;
         7'b1001111: code_val = 4'd1;
         7'b0010010: code_val = 4'd2;
         7'b0000110: code_val = 4'd3;
         7'b1001100: code_val = 4'd4;
         7'b0100100: code_val = 4'd5;
         7'b0100000: code_val = 4'd6;
         7'b0001111: code_val = 4'd7;
         7'b0000000: code_val = 4'd8;
         7'b0000100: code_val = 4'd9;
         7'b1111111: code_blank = 1'b1;
         default:    code_ok = 1'b0;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_seg <= '1;
         p_seg <= '1;
         s_an <= '1;
         p_an <= '1;
         state <= IDLE;
         cnt <= '0;
         seen <= '0;
         digits <= '0;
         digit_valid <= '0;
         blank <= '0;
         commit <= 1'b0;
         commit_idx <= '0;
         bad_pattern <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         s_seg <= seg_n;
         s_an <= an_n;
         p_seg <= s_seg;
         p_an <= s_an;
         state <= state_nxt;
         cnt <= cnt_nxt;
         commit <= 1'b0;
         bad_pattern <= 1'b0;
         frame_done <= 1'b0;
         if (accept && !code_ok)
            bad_pattern <= 1'b1;
         else if (accept) begin
            digits[4*idx +: 4] <= code_val;
            digit_valid[idx] <= 1'b1;
            blank[idx] <= code_blank;
            commit <= 1'b1;
            commit_idx <= idx;
            // a completed frame clears the mask, dropping the bit set by this very commit
            frame_done <= &seen_all;
            seen <= (&seen_all) ? '0 : seen_all;
         end
      end
   end
endmodule
